// File: rtl/canny4_nms.sv
// Canny stage 4: 3x3 non-maximum suppression of the Sobel magnitude along a 4-sector gradient direction.
// Optional build macro CANNY_NMS_LOWCUT_EN adds a LOW_TH magnitude floor to the keep decision.
module canny4_nms #(
  parameter int unsigned IMG_WIDTH = 1024,
  parameter int unsigned COL_W     = 11,
  parameter int unsigned LOW_TH    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] Gx,
  input  logic [7:0] Gy,
  input  logic [7:0] Mxy,
  input  logic       sobel_hs,
  input  logic       sobel_vs,
  input  logic       sobel_de,
  output logic [7:0] nms_data,
  output logic       nms_hs,
  output logic       nms_vs,
  output logic       nms_de
);

  localparam int unsigned AW    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned ROW_W = 2;

  if ((2 ** COL_W) <= IMG_WIDTH || LOW_TH > 255) begin : g_bad_cfg
    $error("canny4_nms: COL_W too small for IMG_WIDTH, or LOW_TH exceeds 8 bits");
  end

  logic [7:0]       lb1_mem [IMG_WIDTH];
  logic [7:0]       lb2_mem [IMG_WIDTH];
  logic [15:0]      gb_mem  [IMG_WIDTH];

  logic [2:0]       hs_sr_q, hs_sr_d, vs_sr_q, vs_sr_d, de_sr_q, de_sr_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [8:0][7:0]  win_q, win_d;
  logic [15:0]      gprev_q, gprev_d, cg_q, cg_d;
  logic             border_q, border_d;
  logic [7:0]       c2_q, c2_d, n1_q, n1_d, n2_q, n2_d;
  logic             bord2_q, bord2_d;
  logic [7:0]       data_q, data_d;

  logic [AW-1:0]    addr_c;
  logic [7:0]       lb1_rd_c, lb2_rd_c;
  logic [15:0]      gb_rd_c;
  logic             de_fall_c, vs_rise_c, keep_c;
  logic [7:0]       ax_c, ay_c, ax2_c, ay2_c;

  assign addr_c   = col_q[AW-1:0];
  assign lb1_rd_c = lb1_mem[addr_c];
  assign lb2_rd_c = lb2_mem[addr_c];
  assign gb_rd_c  = gb_mem[addr_c];

  // Line buffers: read-before-write, line-1 cascades into line-2
  always_ff @(posedge clk) begin
    if (sobel_de) begin
      lb1_mem[addr_c] <= Mxy;
      lb2_mem[addr_c] <= lb1_rd_c;
      gb_mem[addr_c]  <= {Gx, Gy};
    end
  end

  assign de_fall_c = de_sr_q[0] & ~sobel_de;
  assign vs_rise_c = sobel_vs & ~vs_sr_q[0];

  assign ax_c  = {1'b0, cg_q[14:8]};
  assign ay_c  = {1'b0, cg_q[6:0]};
  assign ax2_c = {cg_q[14:8], 1'b0};
  assign ay2_c = {cg_q[6:0], 1'b0};

  always_comb begin
    hs_sr_d  = {hs_sr_q[1:0], sobel_hs};
    vs_sr_d  = {vs_sr_q[1:0], sobel_vs};
    de_sr_d  = {de_sr_q[1:0], sobel_de};
    col_d    = col_q;
    row_d    = row_q;
    win_d    = win_q;
    gprev_d  = gprev_q;
    cg_d     = cg_q;
    border_d = border_q;
    c2_d     = win_q[4];
    n1_d     = win_q[3];
    n2_d     = win_q[5];
    bord2_d  = border_q;
    keep_c   = 1'b0;
    data_d   = 8'd0;

    if (sobel_de) begin
      col_d = col_q + COL_W'(1);
    end else if (de_fall_c) begin
      col_d = '0;
    end

    // A frame start outranks a coincident end of line
    if (vs_rise_c) begin
      row_d = '0;
    end else if (de_fall_c && (row_q != {ROW_W{1'b1}})) begin
      row_d = row_q + ROW_W'(1);
    end

    if (sobel_de) begin
      win_d    = {Mxy, win_q[8:7], lb1_rd_c, win_q[5:4], lb2_rd_c, win_q[2:1]};
      gprev_d  = gb_rd_c;
      cg_d     = gprev_q;
      border_d = (row_q < ROW_W'(2)) || (col_q < COL_W'(2));
    end

    // Sector select; horizontal is the default above
    if (ay2_c <= ax_c) begin
      n1_d = win_q[3];
      n2_d = win_q[5];
    end else if (ax2_c <= ay_c) begin
      n1_d = win_q[1];
      n2_d = win_q[7];
    end else if (cg_q[15] == cg_q[7]) begin
      n1_d = win_q[0];
      n2_d = win_q[8];
    end else begin
      n1_d = win_q[2];
      n2_d = win_q[6];
    end

    keep_c = (c2_q > n1_q) && (c2_q >= n2_q) && !bord2_q;
`ifdef CANNY_NMS_LOWCUT_EN
    keep_c = keep_c && (c2_q >= 8'(LOW_TH));
`endif
    if (keep_c && de_sr_q[1]) begin
      data_d = c2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_sr_q  <= '0;
      vs_sr_q  <= '0;
      de_sr_q  <= '0;
      col_q    <= '0;
      row_q    <= '0;
      win_q    <= '0;
      gprev_q  <= '0;
      cg_q     <= '0;
      border_q <= 1'b0;
      c2_q     <= '0;
      n1_q     <= '0;
      n2_q     <= '0;
      bord2_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      hs_sr_q  <= hs_sr_d;
      vs_sr_q  <= vs_sr_d;
      de_sr_q  <= de_sr_d;
      col_q    <= col_d;
      row_q    <= row_d;
      win_q    <= win_d;
      gprev_q  <= gprev_d;
      cg_q     <= cg_d;
      border_q <= border_d;
      c2_q     <= c2_d;
      n1_q     <= n1_d;
      n2_q     <= n2_d;
      bord2_q  <= bord2_d;
      data_q   <= data_d;
    end
  end

  assign nms_data = data_q;
  assign nms_hs   = hs_sr_q[2];
  assign nms_vs   = vs_sr_q[2];
  assign nms_de   = de_sr_q[2];

endmodule
